// File: rtl/image_write_pkg.sv
// Shared types and BMP header constants for the image_write frame sink.
// The header ROM is a pure function of the image size.
package image_write_pkg;

  typedef enum logic [1:0] {
    ST_CAPTURE = 2'd0,
    ST_HDR     = 2'd1,
    ST_PIX     = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int unsigned BMP_HDR_BYTES = 54;
  localparam int unsigned BMP_RES       = 2835;

  // Bytes 2..53 are thirteen little-endian 32-bit words; planes/bpp pack into word 6.
  function automatic logic [7:0] bmp_hdr_byte(input logic [31:0] idx,
                                               input logic [31:0] width,
                                               input logic [31:0] height);
    logic [31:0] img_size;
    logic [31:0] off;
    logic [31:0] word;
    logic [7:0]  byte_v;
    img_size = width * height * 32'd3;
    off      = idx - 32'd2;
    case (off >> 2)
      32'd0:          word = img_size + BMP_HDR_BYTES;
      32'd2:          word = BMP_HDR_BYTES;
      32'd3:          word = 32'd40;
      32'd4:          word = width;
      32'd5:          word = height;
      32'd6:          word = 32'h0018_0001;
      32'd8:          word = img_size;
      32'd9, 32'd10:  word = BMP_RES;
      default:        word = 32'd0;
    endcase
    case (off[1:0])
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
    if (idx == 32'd0) byte_v = 8'h42;
    if (idx == 32'd1) byte_v = 8'h4D;
    return byte_v;
  endfunction

endpackage

// File: rtl/image_write_if.sv
// Pixel input bus and byte-stream output handshake of image_write.
interface image_write_if;
  logic       HSYNC;
  logic [7:0] DATA_R0, DATA_G0, DATA_B0;
  logic [7:0] DATA_R1, DATA_G1, DATA_B1;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;

  modport master (
    output HSYNC, DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1, out_ready,
    input  out_valid, out_data, out_last
  );

  modport slave (
    input  HSYNC, DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1, out_ready,
    output out_valid, out_data, out_last
  );
endinterface

// File: rtl/image_write_buf.sv
// Frame pixel store: two same-cycle write ports (even/odd pixel), one registered read port.
// Contents are deliberately not reset.
module image_write_buf #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          HCLK,
  input  logic          we,
  input  logic [AW-1:0] waddr0,
  input  logic [23:0]   wdata0,
  input  logic [AW-1:0] waddr1,
  input  logic [23:0]   wdata1,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [23:0]   rdata
);

  logic [23:0] mem [DEPTH];

  always_ff @(posedge HCLK) begin
    if (we) begin
      mem[waddr0] <= wdata0;
      mem[waddr1] <= wdata1;
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/image_write.sv
// Captures one RGB888 frame (two pixels per HSYNC beat) in BMP bottom-up order,
// then replays it as a 54-byte BMP header plus B,G,R pixel bytes on a valid/ready stream.
//
// state      | meaning
// ST_CAPTURE | writing incoming beats into the buffer
// ST_HDR     | next byte loaded into the output register is a header byte
// ST_PIX     | next byte loaded comes from the buffer word in rdata
// ST_DONE    | final byte accepted; idle until reset
module image_write
  import image_write_pkg::*;
#(
  parameter int WIDTH  = 100,
  parameter int HEIGHT = 100
) (
  input  logic        HCLK,
  input  logic        HRESET,
  image_write_if.slave bus,
  output logic        frame_captured,
  output logic        dump_done,
  output logic        overrun
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int AW   = $clog2(NPIX);
  localparam int CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int RW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 2);
  localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT - 1);
  localparam logic [AW-1:0] PIX_LAST  = AW'(NPIX - 1);
  localparam logic [AW-1:0] BASE_INIT = AW'(WIDTH * (HEIGHT - 1));

  state_t        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [AW-1:0] base_q, base_d;
  logic [31:0]   hdr_idx_q, hdr_idx_d;
  logic [AW-1:0] pix_addr_q, pix_addr_d;
  logic [1:0]    ch_q, ch_d;
  logic          valid_q, valid_d;
  logic [7:0]    data_q, data_d;
  logic          last_q, last_d;
  logic          fc_q, fc_d;
  logic          done_q, done_d;
  logic          ovr_q, ovr_d;

  logic          load;
  logic          we, re;
  logic [AW-1:0] waddr0, waddr1, raddr;
  logic [23:0]   rdata;

  // base tracks WIDTH*(HEIGHT-1-row), so the write address needs no multiplier
  assign waddr0 = base_q + AW'(col_q);
  assign waddr1 = waddr0 + 1'b1;

  image_write_buf #(.DEPTH(NPIX), .AW(AW)) u_buf (
    .HCLK   (HCLK),
    .we     (we),
    .waddr0 (waddr0),
    .wdata0 ({bus.DATA_R0, bus.DATA_G0, bus.DATA_B0}),
    .waddr1 (waddr1),
    .wdata1 ({bus.DATA_R1, bus.DATA_G1, bus.DATA_B1}),
    .re     (re),
    .raddr  (raddr),
    .rdata  (rdata)
  );

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= ST_CAPTURE;
      row_q      <= '0;
      col_q      <= '0;
      base_q     <= BASE_INIT;
      hdr_idx_q  <= '0;
      pix_addr_q <= '0;
      ch_q       <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
      fc_q       <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      base_q     <= base_d;
      hdr_idx_q  <= hdr_idx_d;
      pix_addr_q <= pix_addr_d;
      ch_q       <= ch_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      last_q     <= last_d;
      fc_q       <= fc_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    base_d     = base_q;
    hdr_idx_d  = hdr_idx_q;
    pix_addr_d = pix_addr_q;
    ch_d       = ch_q;
    valid_d    = valid_q;
    data_d     = data_q;
    last_d     = last_q;
    fc_d       = fc_q;
    done_d     = done_q;
    ovr_d      = ovr_q;
    we         = 1'b0;
    re         = 1'b0;
    raddr      = '0;
    load       = !valid_q || bus.out_ready;

    if (bus.HSYNC && state_q != ST_CAPTURE) ovr_d = 1'b1;

    case (state_q)
      ST_CAPTURE: begin
        if (bus.HSYNC) begin
          we = 1'b1;
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              state_d   = ST_HDR;
              fc_d      = 1'b1;
              valid_d   = 1'b1;
              data_d    = bmp_hdr_byte(32'd0, 32'(WIDTH), 32'(HEIGHT));
              hdr_idx_d = 32'd1;
            end else begin
              row_d  = row_q + 1'b1;
              base_d = base_q - AW'(WIDTH);
            end
          end else begin
            col_d = col_q + CW'(2);
          end
        end
      end
      ST_HDR: begin
        // keep word 0 prefetched so the first pixel byte follows the header without a bubble
        re = 1'b1;
        if (load) begin
          data_d    = bmp_hdr_byte(hdr_idx_q, 32'(WIDTH), 32'(HEIGHT));
          hdr_idx_d = hdr_idx_q + 32'd1;
          if (hdr_idx_q == BMP_HDR_BYTES - 1) state_d = ST_PIX;
        end
      end
      ST_PIX: begin
        if (last_q && bus.out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (load) begin
          case (ch_q)
            2'd0:    data_d = rdata[7:0];
            2'd1:    data_d = rdata[15:8];
            default: data_d = rdata[23:16];
          endcase
          if (ch_q == 2'd2) begin
            ch_d = 2'd0;
            if (pix_addr_q == PIX_LAST) begin
              last_d = 1'b1;
            end else begin
              re         = 1'b1;
              raddr      = pix_addr_q + 1'b1;
              pix_addr_d = pix_addr_q + 1'b1;
            end
          end else begin
            ch_d = ch_q + 2'd1;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.out_valid   = valid_q;
  assign bus.out_data    = data_q;
  assign bus.out_last    = last_q;
  assign frame_captured  = fc_q;
  assign dump_done       = done_q;
  assign overrun         = ovr_q;

endmodule

// File: tb/tb_image_write.sv
// Directed/random bench for image_write on a 4x2 frame: a reference model builds the
// expected BMP byte file from the captured pixels and every accepted byte is compared.
module tb_image_write;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int NB = 54 + W * H * 3;

  logic HCLK = 1'b0;
  logic HRESET = 1'b0;
  logic frame_captured, dump_done, overrun;

  image_write_if bus ();

  image_write #(.WIDTH(W), .HEIGHT(H)) dut (
    .HCLK           (HCLK),
    .HRESET         (HRESET),
    .bus            (bus),
    .frame_captured (frame_captured),
    .dump_done      (dump_done),
    .overrun        (overrun)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;

  logic [7:0] mr [H][W];
  logic [7:0] mg [H][W];
  logic [7:0] mb [H][W];
  logic [7:0] expq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push32(input logic [31:0] v);
    for (int i = 0; i < 4; i++) expq.push_back(v[8*i +: 8]);
  endtask

  task automatic push16(input logic [15:0] v);
    expq.push_back(v[7:0]);
    expq.push_back(v[15:8]);
  endtask

  // Expected file: BMP header fields, then rows from the bottom of the image up, B,G,R per pixel.
  task automatic build_expected();
    expq.delete();
    expq.push_back(8'h42);
    expq.push_back(8'h4D);
    push32(54 + W * H * 3);
    push32(0);
    push32(54);
    push32(40);
    push32(W);
    push32(H);
    push16(1);
    push16(24);
    push32(0);
    push32(W * H * 3);
    push32(2835);
    push32(2835);
    push32(0);
    push32(0);
    for (int r = H - 1; r >= 0; r--)
      for (int c = 0; c < W; c++) begin
        expq.push_back(mb[r][c]);
        expq.push_back(mg[r][c]);
        expq.push_back(mr[r][c]);
      end
  endtask

  task automatic do_reset();
    bus.HSYNC = 1'b0;
    HRESET = 1'b1;
    #2;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_fc", frame_captured, 0);
    chk("rst_done", dump_done, 0);
    chk("rst_overrun", overrun, 0);
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
  endtask

  task automatic send_frame(input bit pattern, input int gap_max, input int abort_beat);
    int beat;
    int gaps;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        mr[r][c] = pattern ? 8'(r * 64 + c * 4 + 0) : 8'($urandom);
        mg[r][c] = pattern ? 8'(r * 64 + c * 4 + 1) : 8'($urandom);
        mb[r][c] = pattern ? 8'(r * 64 + c * 4 + 2) : 8'($urandom);
      end
    beat = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c += 2) begin
        gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        bus.HSYNC = 1'b0;
        repeat (gaps) begin
          @(posedge HCLK);
          #1;
          chk("fc_gap", frame_captured, 0);
        end
        if (beat == abort_beat) begin
          do_reset();
          return;
        end
        bus.DATA_R0 = mr[r][c];   bus.DATA_G0 = mg[r][c];   bus.DATA_B0 = mb[r][c];
        bus.DATA_R1 = mr[r][c+1]; bus.DATA_G1 = mg[r][c+1]; bus.DATA_B1 = mb[r][c+1];
        bus.HSYNC = 1'b1;
        @(posedge HCLK);
        #1;
        bus.HSYNC = 1'b0;
        if (r == H - 1 && c == W - 2) begin
          chk("fc_rise", frame_captured, 1);
          chk("first_valid", bus.out_valid, 1);
          chk("first_byte", bus.out_data, 8'h42);
        end else begin
          chk("fc_early", frame_captured, 0);
          chk("valid_early", bus.out_valid, 0);
        end
        beat++;
      end
  endtask

  // Consume up to stop_at bytes; optionally stall randomly and pulse HSYNC while at byte hsync_at.
  task automatic dump(input bit rand_ready, input int hsync_at, input int stop_at);
    int  n;
    int  cyc;
    bit  r;
    logic v, l;
    logic [7:0] d;
    n = 0;
    cyc = 0;
    while (n < stop_at && cyc < 2000) begin
      r = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.out_ready = r;
      bus.HSYNC = (n == hsync_at);
      bus.DATA_R0 = 8'($urandom); bus.DATA_G0 = 8'($urandom); bus.DATA_B0 = 8'($urandom);
      bus.DATA_R1 = 8'($urandom); bus.DATA_G1 = 8'($urandom); bus.DATA_B1 = 8'($urandom);
      v = bus.out_valid;
      d = bus.out_data;
      l = bus.out_last;
      @(posedge HCLK);
      #1;
      cyc++;
      bus.HSYNC = 1'b0;
      if (v && r) begin
        chk($sformatf("byte%0d", n), d, expq[n]);
        chk($sformatf("last%0d", n), l, (n == NB - 1));
        n++;
      end else if (v) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_data", bus.out_data, d);
        chk("hold_last", bus.out_last, l);
      end else begin
        chk("valid_drop", v, 1);
      end
    end
    chk("dump_count", n, stop_at);
    if (!rand_ready) chk("throughput", cyc, stop_at);
    if (n == NB) begin
      chk("dump_done", dump_done, 1);
      chk("valid_after", bus.out_valid, 0);
    end else begin
      chk("dump_done_early", dump_done, 0);
    end
    chk("overrun", overrun, (hsync_at >= 0 && hsync_at < n));
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.HSYNC = 1'b0;
    bus.out_ready = 1'b0;
    bus.DATA_R0 = '0; bus.DATA_G0 = '0; bus.DATA_B0 = '0;
    bus.DATA_R1 = '0; bus.DATA_G1 = '0; bus.DATA_B1 = '0;
    #1;
    do_reset();

    // pattern frame, gap-free capture, ready held high
    send_frame(1'b1, 0, -1);
    build_expected();
    dump(1'b0, -1, NB);

    // terminal state ignores beats but flags them
    bus.HSYNC = 1'b1;
    @(posedge HCLK);
    #1;
    bus.HSYNC = 1'b0;
    chk("done_overrun", overrun, 1);
    chk("done_valid", bus.out_valid, 0);
    chk("done_hold", dump_done, 1);

    // random pixels, random HSYNC gaps, random backpressure
    do_reset();
    send_frame(1'b0, 3, -1);
    build_expected();
    dump(1'b1, -1, NB);

    // reset at beat 3, then a full frame; HSYNC pulsed during the header
    do_reset();
    send_frame(1'b0, 2, 3);
    send_frame(1'b0, 2, -1);
    build_expected();
    dump(1'b1, 10, NB);

    // reset mid-dump at byte 20, then a clean frame
    do_reset();
    send_frame(1'b0, 1, -1);
    build_expected();
    dump(1'b1, 5, 20);
    do_reset();
    send_frame(1'b0, 0, -1);
    build_expected();
    dump(1'b0, -1, NB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
